cpu_retire_tracer: RTL and testbench

- Synthesizable retire-trace monitor directly downstream of cpu_top; consumes its per-cycle retire signals (PC, Inst, RegWrite, WriteRegister, WriteData, MemRead, MemWrite, MemAddress, MemData, Halt).
- Classifies each run cycle into one trace record (REG, LOAD, STORE, NOP, HALT), numbers it, and buffers it in a FIFO drained over a valid/ready port (to DMA/host or a bench checker).
- Maintains cycle and instruction counters, a halt-stop state machine and a watchdog timeout.

---
 rtl/cpu_trace_pkg.sv | 45 ++++
 rtl/trace_fifo.sv | 49 ++++
 rtl/cpu_retire_tracer.sv | 164 ++++++++++++++++
 tb/tb_cpu_retire_tracer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared types for the retire-trace monitor: record kinds, record layout and tracer states.
package cpu_trace_pkg;

  typedef enum logic [2:0] {
    TR_REG   = 3'd0,
    TR_LOAD  = 3'd1,
    TR_STORE = 3'd2,
    TR_NOP   = 3'd3,
    TR_HALT  = 3'd4
  } trace_kind_t;

  typedef struct packed {
    trace_kind_t kind;
    logic [31:0] inum;
    logic [31:0] pc;
    logic [4:0]  regIdx;
    logic [31:0] value;
    logic [31:0] addr;
  } trace_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED,
    ST_TIMEOUT
  } tracer_state_t;

  localparam int TRACE_REC_W = $bits(trace_rec_t);

  // A register write outranks a halt retiring in the same cycle.
  function automatic trace_kind_t classifyRetire(input logic regWrite, input logic memRead,
                                                 input logic memWrite, input logic halt);
    if (regWrite && memRead)
      return TR_LOAD;
    else if (regWrite)
      return TR_REG;
    else if (halt)
      return TR_HALT;
    else if (memWrite)
      return TR_STORE;
    else
      return TR_NOP;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO succeeds when a pop shares the edge.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign rdData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush)
        wrPtr <= wrPtr + PTR_ONE;
      if (doPop)
        rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // Storage is deliberately left out of reset; the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (doPush)
      mem[wrPtr[AW-1:0]] <= wrData;
  end

endmodule

// File: rtl/cpu_retire_tracer.sv
// Retire-trace monitor: turns every RUN cycle of the core into one numbered record and queues it for a consumer.
module cpu_retire_tracer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 100000,
  parameter int DROP_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [31:0]       PC,
  input  logic [31:0]       Inst,
  input  logic              RegWrite,
  input  logic [4:0]        WriteRegister,
  input  logic [31:0]       WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       MemAddress,
  input  logic [31:0]       MemData,
  input  logic              Halt,
  output logic              tr_valid,
  input  logic              tr_ready,
  output trace_kind_t       tr_kind,
  output logic [31:0]       tr_inum,
  output logic [31:0]       tr_pc,
  output logic [4:0]        tr_reg,
  output logic [31:0]       tr_value,
  output logic [31:0]       tr_addr,
  output logic [31:0]       cycle_count,
  output logic [31:0]       inst_count,
  output logic              halted,
  output logic              timeout,
  output logic              done,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  tracer_state_t            state;
  tracer_state_t            stateNext;
  trace_kind_t              newKind;
  trace_rec_t               newRec;
  trace_rec_t               fifoHead;
  trace_rec_t               lastRec;
  trace_rec_t               shownRec;
  logic [TRACE_REC_W-1:0]   fifoRdData;
  logic                     fifoFull;
  logic                     fifoEmpty;
  logic                     running;
  logic                     pop;
  logic                     drop;
  logic                     lastWatchdog;
  logic                     unusedInst;

  assign unusedInst   = ^Inst;
  assign running      = (state == ST_RUN);
  assign pop          = tr_valid && tr_ready;
  assign drop         = running && fifoFull && !pop;
  assign lastWatchdog = (cycle_count == 32'(MAX_CYCLES - 1));
  assign newKind      = classifyRetire(RegWrite, MemRead, MemWrite, Halt);

  always_comb begin
    newRec      = '0;
    newRec.kind = newKind;
    newRec.inum = inst_count;
    newRec.pc   = PC;
    case (newKind)
      TR_REG: begin
        newRec.regIdx = WriteRegister;
        newRec.value  = WriteData;
      end
      TR_LOAD: begin
        newRec.regIdx = WriteRegister;
        newRec.value  = WriteData;
        newRec.addr   = MemAddress;
      end
      TR_STORE: begin
        newRec.value = MemData;
        newRec.addr  = MemAddress;
      end
      default: ;
    endcase
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_REC_W)
  ) fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (running),
    .pop    (pop),
    .wrData (newRec),
    .rdData (fifoRdData),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  assign fifoHead = trace_rec_t'(fifoRdData);

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= stateNext;
  end

  // A halt on the final watchdog cycle is checked first so it wins over the timeout.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:
        if (en)
          stateNext = ST_RUN;
      ST_RUN:
        if (newKind == TR_HALT)
          stateNext = ST_HALTED;
        else if (lastWatchdog)
          stateNext = ST_TIMEOUT;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      inst_count  <= '0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else if (running) begin
      cycle_count <= cycle_count + 32'd1;
      inst_count  <= inst_count + 32'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1)
          drop_count <= drop_count + DROP_ONE;
      end
    end
  end

  // Keep the last popped record so the trace port holds its values while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst)
      lastRec <= '0;
    else if (pop)
      lastRec <= fifoHead;
  end

  assign shownRec = fifoEmpty ? lastRec : fifoHead;
  assign tr_valid = !fifoEmpty;
  assign tr_kind  = shownRec.kind;
  assign tr_inum  = shownRec.inum;
  assign tr_pc    = shownRec.pc;
  assign tr_reg   = shownRec.regIdx;
  assign tr_value = shownRec.value;
  assign tr_addr  = shownRec.addr;

  assign halted  = (state == ST_HALTED);
  assign timeout = (state == ST_TIMEOUT);
  assign done    = (halted || timeout) && fifoEmpty;

endmodule

// File: tb/tb_cpu_retire_tracer.sv
// Bench for cpu_retire_tracer: directed scenarios plus a randomized run checked against a queue-based model.
module tb_cpu_retire_tracer;
  import cpu_trace_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;
  localparam int T_MAX  = 8;

  typedef struct {
    trace_kind_t kind;
    logic [31:0] inum;
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] value;
    logic [31:0] addr;
  } exp_rec_t;

  logic clk = 1'b0;
  logic rst, en, RegWrite, MemRead, MemWrite, Halt, tr_ready;
  logic [31:0] PC, Inst, WriteData, MemAddress, MemData;
  logic [4:0] WriteRegister;

  logic tr_valid, halted, timeout, done, overflow;
  trace_kind_t tr_kind;
  logic [31:0] tr_inum, tr_pc, tr_value, tr_addr, cycle_count, inst_count;
  logic [4:0] tr_reg;
  logic [DROP_W-1:0] drop_count;

  logic tValid, tHalted, tTimeout, tDone, tOverflow;
  trace_kind_t tKind;
  logic [31:0] tInum, tPc, tValue, tAddr, tCycle, tInst;
  logic [4:0] tReg;
  logic [DROP_W-1:0] tDrop;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_retire_tracer #(.DEPTH(DEPTH), .MAX_CYCLES(1000), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .en(en), .PC(PC), .Inst(Inst), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemAddress(MemAddress), .MemData(MemData), .Halt(Halt), .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_kind(tr_kind), .tr_inum(tr_inum), .tr_pc(tr_pc), .tr_reg(tr_reg), .tr_value(tr_value),
    .tr_addr(tr_addr), .cycle_count(cycle_count), .inst_count(inst_count), .halted(halted),
    .timeout(timeout), .done(done), .overflow(overflow), .drop_count(drop_count)
  );

  // Short watchdog so timeout behaviour is reachable in a few cycles.
  cpu_retire_tracer #(.DEPTH(DEPTH), .MAX_CYCLES(T_MAX), .DROP_W(DROP_W)) dutT (
    .clk(clk), .rst(rst), .en(en), .PC(PC), .Inst(Inst), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemAddress(MemAddress), .MemData(MemData), .Halt(Halt), .tr_valid(tValid), .tr_ready(tr_ready),
    .tr_kind(tKind), .tr_inum(tInum), .tr_pc(tPc), .tr_reg(tReg), .tr_value(tValue),
    .tr_addr(tAddr), .cycle_count(tCycle), .inst_count(tInst), .halted(tHalted),
    .timeout(tTimeout), .done(tDone), .overflow(tOverflow), .drop_count(tDrop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    en = 1'b0; PC = '0; Inst = '0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    MemRead = 1'b0; MemWrite = 1'b0; MemAddress = '0; MemData = '0; Halt = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic startRun();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    tr_ready = 1'b0;
    doReset();
    checks++; if (tr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0d want=0", tr_valid); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL rst_cycle got=%0d want=0", cycle_count); end
    checks++; if (inst_count !== 32'd0) begin errors++; $display("FAIL rst_inst got=%0d want=0", inst_count); end
    checks++; if ({halted, timeout, done, overflow} !== 4'b0) begin errors++; $display("FAIL rst_flags got=%b want=0000", {halted, timeout, done, overflow}); end
    checks++; if (drop_count !== '0) begin errors++; $display("FAIL rst_drop got=%0d want=0", drop_count); end
    checks++; if ({tr_kind, tr_inum, tr_pc, tr_reg, tr_value, tr_addr} !== '0) begin errors++; $display("FAIL rst_trace got=%0d/%0d/%h want=zeros", tr_kind, tr_inum, tr_pc); end
  endtask

  task automatic test_single_reg();
    doReset();
    tr_ready = 1'b1;
    startRun();
    RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'h1234; PC = 32'h10;
    tick();
    checks++; if (tr_valid !== 1'b1) begin errors++; $display("FAIL reg_valid got=%0d want=1", tr_valid); end
    checks++; if (tr_kind !== TR_REG) begin errors++; $display("FAIL reg_kind got=%0d want=%0d", tr_kind, TR_REG); end
    checks++; if (tr_inum !== 32'd0) begin errors++; $display("FAIL reg_inum got=%0d want=0", tr_inum); end
    checks++; if (tr_reg !== 5'd3 || tr_value !== 32'h1234) begin errors++; $display("FAIL reg_payload got=%0d/%h want=3/1234", tr_reg, tr_value); end
    checks++; if (tr_addr !== 32'd0 || tr_pc !== 32'h10) begin errors++; $display("FAIL reg_addr_pc got=%h/%h want=0/10", tr_addr, tr_pc); end
    clearInputs();
  endtask

  task automatic test_sequence();
    doReset();
    tr_ready = 1'b1;
    startRun();
    RegWrite = 1'b1; MemRead = 1'b1; WriteRegister = 5'd7; WriteData = 32'h55; MemAddress = 32'h40; PC = 32'h20;
    tick();
    checks++; if (tr_kind !== TR_LOAD || tr_inum !== 32'd0) begin errors++; $display("FAIL load_kind got=%0d/%0d want=1/0", tr_kind, tr_inum); end
    checks++; if (tr_reg !== 5'd7 || tr_value !== 32'h55 || tr_addr !== 32'h40) begin errors++; $display("FAIL load_payload got=%0d/%h/%h want=7/55/40", tr_reg, tr_value, tr_addr); end
    clearInputs();
    MemWrite = 1'b1; MemAddress = 32'h44; MemData = 32'h99; WriteData = 32'hdead; WriteRegister = 5'd9; PC = 32'h24;
    tick();
    checks++; if (tr_kind !== TR_STORE || tr_inum !== 32'd1) begin errors++; $display("FAIL store_kind got=%0d/%0d want=2/1", tr_kind, tr_inum); end
    checks++; if (tr_reg !== 5'd0 || tr_value !== 32'h99 || tr_addr !== 32'h44) begin errors++; $display("FAIL store_payload got=%0d/%h/%h want=0/99/44", tr_reg, tr_value, tr_addr); end
    clearInputs();
    PC = 32'h28; MemAddress = 32'h77;
    tick();
    checks++; if (tr_kind !== TR_NOP || tr_inum !== 32'd2 || tr_addr !== 32'd0) begin errors++; $display("FAIL nop_rec got=%0d/%0d/%h want=3/2/0", tr_kind, tr_inum, tr_addr); end
    clearInputs();
    Halt = 1'b1; PC = 32'h2c;
    tick();
    checks++; if (tr_kind !== TR_HALT || tr_inum !== 32'd3) begin errors++; $display("FAIL halt_kind got=%0d/%0d want=4/3", tr_kind, tr_inum); end
    checks++; if (halted !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL halt_flags got=%0d/%0d want=1/0", halted, done); end
    clearInputs();
    RegWrite = 1'b1; WriteRegister = 5'd1;
    tick();
    tick();
    checks++; if (done !== 1'b1 || tr_valid !== 1'b0) begin errors++; $display("FAIL halt_drain got=%0d/%0d want=1/0", done, tr_valid); end
    checks++; if (inst_count !== 32'd4 || cycle_count !== 32'd4) begin errors++; $display("FAIL halt_counts got=%0d/%0d want=4/4", inst_count, cycle_count); end
    checks++; if (tr_kind !== TR_HALT || tr_pc !== 32'h2c) begin errors++; $display("FAIL halt_hold got=%0d/%h want=4/2c", tr_kind, tr_pc); end
    clearInputs();
  endtask

  task automatic test_overflow();
    doReset();
    tr_ready = 1'b0;
    startRun();
    for (int i = 0; i < 20; i++) tick();
    checks++; if (overflow !== 1'b1 || drop_count !== 16'd4) begin errors++; $display("FAIL ovf_drop got=%0d/%0d want=1/4", overflow, drop_count); end
    checks++; if (inst_count !== 32'd20) begin errors++; $display("FAIL ovf_inst got=%0d want=20", inst_count); end
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    checks++; if (halted !== 1'b1 || drop_count !== 16'd5 || inst_count !== 32'd21) begin errors++; $display("FAIL ovf_halt got=%0d/%0d/%0d want=1/5/21", halted, drop_count, inst_count); end
    tr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (tr_valid !== 1'b1 || tr_inum !== 32'(i)) begin errors++; $display("FAIL ovf_order got=%0d/%0d want=1/%0d", tr_valid, tr_inum, i); end
      tick();
    end
    checks++; if (tr_valid !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL ovf_drained got=%0d/%0d want=0/1", tr_valid, done); end
  endtask

  task automatic test_full_pop();
    doReset();
    tr_ready = 1'b0;
    startRun();
    for (int i = 0; i < DEPTH; i++) tick();
    tr_ready = 1'b1;
    tick();
    tr_ready = 1'b0;
    checks++; if (drop_count !== '0 || overflow !== 1'b0) begin errors++; $display("FAIL fullpop_drop got=%0d/%0d want=0/0", drop_count, overflow); end
    checks++; if (inst_count !== 32'd17 || tr_inum !== 32'd1) begin errors++; $display("FAIL fullpop_head got=%0d/%0d want=17/1", inst_count, tr_inum); end
    tick();
    checks++; if (drop_count !== 16'd1 || tr_inum !== 32'd1) begin errors++; $display("FAIL fullpop_hold got=%0d/%0d want=1/1", drop_count, tr_inum); end
  endtask

  task automatic test_timeout();
    doReset();
    tr_ready = 1'b1;
    startRun();
    for (int i = 0; i < T_MAX - 1; i++) tick();
    checks++; if (tTimeout !== 1'b0 || tCycle !== 32'(T_MAX - 1)) begin errors++; $display("FAIL to_early got=%0d/%0d want=0/%0d", tTimeout, tCycle, T_MAX - 1); end
    tick();
    checks++; if (tTimeout !== 1'b1 || tHalted !== 1'b0 || tInst !== 32'(T_MAX)) begin errors++; $display("FAIL to_fire got=%0d/%0d/%0d want=1/0/%0d", tTimeout, tHalted, tInst, T_MAX); end
    tick();
    checks++; if (tInst !== 32'(T_MAX) || tDone !== 1'b1) begin errors++; $display("FAIL to_stop got=%0d/%0d want=%0d/1", tInst, tDone, T_MAX); end
    doReset();
    startRun();
    tick();
    RegWrite = 1'b1; Halt = 1'b1; WriteRegister = 5'd2;
    tick();
    clearInputs();
    checks++; if (tKind !== TR_REG || tHalted !== 1'b0) begin errors++; $display("FAIL to_reghalt got=%0d/%0d want=0/0", tKind, tHalted); end
    for (int i = 0; i < T_MAX - 2; i++) tick();
    checks++; if (tTimeout !== 1'b1 || tHalted !== 1'b0) begin errors++; $display("FAIL to_after_reghalt got=%0d/%0d want=1/0", tTimeout, tHalted); end
    doReset();
    startRun();
    for (int i = 0; i < T_MAX - 1; i++) tick();
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    checks++; if (tHalted !== 1'b1 || tTimeout !== 1'b0 || tKind !== TR_HALT) begin errors++; $display("FAIL to_lasthalt got=%0d/%0d/%0d want=1/0/4", tHalted, tTimeout, tKind); end
  endtask

  task automatic test_mid_reset();
    doReset();
    tr_ready = 1'b0;
    startRun();
    RegWrite = 1'b1; WriteRegister = 5'd1; PC = 32'h100;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (tr_valid !== 1'b1 || inst_count !== 32'd5) begin errors++; $display("FAIL mid_pre got=%0d/%0d want=1/5", tr_valid, inst_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (tr_valid !== 1'b0 || inst_count !== 32'd0 || cycle_count !== 32'd0) begin errors++; $display("FAIL mid_clear got=%0d/%0d/%0d want=0/0/0", tr_valid, inst_count, cycle_count); end
    checks++; if (tr_pc !== 32'd0 || tr_reg !== 5'd0) begin errors++; $display("FAIL mid_trace got=%h/%0d want=0/0", tr_pc, tr_reg); end
    tick();
    tick();
    checks++; if (inst_count !== 32'd0 || tr_valid !== 1'b0) begin errors++; $display("FAIL mid_idle got=%0d/%0d want=0/0", inst_count, tr_valid); end
    startRun();
    RegWrite = 1'b1; WriteRegister = 5'd6;
    tick();
    checks++; if (tr_valid !== 1'b1 || tr_inum !== 32'd0 || tr_reg !== 5'd6) begin errors++; $display("FAIL mid_restart got=%0d/%0d/%0d want=1/0/6", tr_valid, tr_inum, tr_reg); end
    clearInputs();
  endtask

  task automatic test_random();
    exp_rec_t q[$];
    exp_rec_t r;
    bit mRun, mHalted;
    int mInst, mDrops;
    doReset();
    tr_ready = 1'b0;
    startRun();
    mRun = 1'b1; mHalted = 1'b0; mInst = 0; mDrops = 0;
    for (int cyc = 0; cyc < 340; cyc++) begin
      PC = $urandom; WriteData = $urandom; MemAddress = $urandom; MemData = $urandom;
      Inst = $urandom; WriteRegister = 5'($urandom_range(0, 31));
      RegWrite = 1'($urandom_range(0, 1)); MemRead = 1'($urandom_range(0, 1));
      MemWrite = 1'($urandom_range(0, 1)); Halt = ($urandom_range(0, 127) == 0);
      tr_ready = ($urandom_range(0, 9) < 4);
      if (cyc >= 300) begin RegWrite = 1'b0; Halt = 1'b1; tr_ready = 1'b1; end
      checks++; if (tr_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0d want=%0d", cyc, tr_valid, q.size() > 0); end
      checks++; if (inst_count !== 32'(mInst)) begin errors++; $display("FAIL rnd_inst cyc=%0d got=%0d want=%0d", cyc, inst_count, mInst); end
      if (q.size() > 0) begin
        checks++;
        if (tr_kind !== q[0].kind || tr_inum !== q[0].inum || tr_pc !== q[0].pc ||
            tr_reg !== q[0].rg || tr_value !== q[0].value || tr_addr !== q[0].addr) begin
          errors++;
          $display("FAIL rnd_rec cyc=%0d got=%0d/%0d/%h/%0d/%h/%h want=%0d/%0d/%h/%0d/%h/%h", cyc,
                   tr_kind, tr_inum, tr_pc, tr_reg, tr_value, tr_addr,
                   q[0].kind, q[0].inum, q[0].pc, q[0].rg, q[0].value, q[0].addr);
        end
      end
      if (q.size() > 0 && tr_ready) void'(q.pop_front());
      if (mRun) begin
        r = '{kind: TR_NOP, inum: 32'(mInst), pc: PC, rg: 5'd0, value: 32'd0, addr: 32'd0};
        if (RegWrite && MemRead) r.kind = TR_LOAD;
        else if (RegWrite) r.kind = TR_REG;
        else if (Halt) r.kind = TR_HALT;
        else if (MemWrite) r.kind = TR_STORE;
        if (r.kind == TR_REG || r.kind == TR_LOAD) begin r.rg = WriteRegister; r.value = WriteData; end
        if (r.kind == TR_STORE) r.value = MemData;
        if (r.kind == TR_LOAD || r.kind == TR_STORE) r.addr = MemAddress;
        mInst++;
        if (q.size() < DEPTH) q.push_back(r);
        else mDrops++;
        if (r.kind == TR_HALT) begin mRun = 1'b0; mHalted = 1'b1; end
      end
      tick();
    end
    checks++; if (halted !== mHalted || done !== 1'b1) begin errors++; $display("FAIL rnd_end got=%0d/%0d want=%0d/1", halted, done, mHalted); end
    checks++; if (drop_count !== DROP_W'(mDrops) || overflow !== (mDrops > 0)) begin errors++; $display("FAIL rnd_drops got=%0d/%0d want=%0d/%0d", drop_count, overflow, mDrops, mDrops > 0); end
    checks++; if (cycle_count !== 32'(mInst)) begin errors++; $display("FAIL rnd_cycles got=%0d want=%0d", cycle_count, mInst); end
    clearInputs();
  endtask

  initial begin
    rst = 1'b1;
    tr_ready = 1'b0;
    clearInputs();
    test_reset();
    test_single_reg();
    test_sequence();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
